led_seq_engine: RTL and testbench
=================================

# led_seq_engine

Parametrised LED sequence engine for the board-demo FSM examples. A table of up to STEPS programmable steps is played out on the LED bus. Each step has its own pattern, its own dwell time and an optional advance gate. The engine supports one-shot and loop modes, an abort input, and a timed FINISH hold with idle/finish status. It sits between the board switch/key debouncers (start, advance, abort) and the LED pins, and is programmed by a local config port while idle.

## Interface
Parameters:
- LED_W, 8: LED bus width.
- STEPS, 8: number of step-table entries (power of two, ≥2); AW = $clog2(STEPS).
- DWELL_W, 8: dwell counter width.
- FINISH_CYCLES, 16: cycles spent in FINISH (≥1).
- IDLE_PATTERN, 8'hAA (LED_W bits): LED value in IDLE.
- FINISH_PATTERN, 8'h18 (LED_W bits): LED value in FINISH.

Ports:
- clk  in  1  single clock, all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; begins a run when sampled high in IDLE.
- advance  in  1  releases a gated step.
- abort  in  1  returns to IDLE from any non-IDLE state.
- loop  in  1  sampled at start; 1 = repeat the table until abort.
- last_step  in  AW  index of the final step; sampled at start.
- cfg_we  in  1  step-table write strobe.
- cfg_addr  in  AW  step index to write.
- cfg_pattern  in  LED_W  pattern to write.
- cfg_dwell  in  DWELL_W  dwell value to write.
- cfg_gate  in  1  gate bit to write.
- leds  out  LED_W  LED drive.
- idle  out  1  high in IDLE.
- busy  out  1  high in RUN or WAIT.
- waiting  out  1  high in WAIT.
- finish  out  1  high in FINISH.
- step_idx  out  AW  current step index; 0 outside RUN/WAIT.

## Operation
- States: IDLE, RUN, WAIT, FINISH. All are one-hot registered.
- Outputs are decoded from the registered state, step index and table, with no input-to-output combinational path:
  - IDLE: leds = IDLE_PATTERN.
  - RUN and WAIT: leds = pattern[step_idx].
  - FINISH: leds = FINISH_PATTERN.
- Reset values: state = IDLE; step table cleared (pattern 0, dwell 0, gate 0); counters 0. Outputs at reset: leds = IDLE_PATTERN, idle = 1, busy = waiting = finish = 0, step_idx = 0.
- Table writes: a write is accepted only when state = IDLE and start = 0. A write accepted on cycle T is visible from T+1. Writes attempted in any other case are dropped.
- IDLE: when start = 1, go to RUN with step_idx = 0 and dwell counter cnt = dwell[0]. loop and last_step are latched on the same edge.
- RUN, each cycle:
  - If cnt ≠ 0: decrement cnt.
  - Else, if gate[k] = 1 and advance = 0: go to WAIT.
  - Else, if k ≠ last: k ← k+1 and cnt ← dwell[k+1].
  - Else, if loop = 1: k ← 0 and cnt ← dwell[0].
  - Else: go to FINISH with the finish counter at 0.
- WAIT: hold k and leds. When advance = 1, take the same next-step action as RUN at cnt = 0.
- FINISH: increment the finish counter. On the cycle the counter equals FINISH_CYCLES−1, go to IDLE.
- abort = 1 in RUN, WAIT or FINISH forces IDLE on the next edge and overrides all other transitions. abort is ignored in IDLE.
- start while not in IDLE is ignored. start held high at FINISH exit begins a new run from the IDLE cycle, so a continuously held start produces back-to-back runs.
- The step index wraps only via the loop rule. last_step = STEPS−1 is legal.

## Timing
- Start latency: start high at edge T gives RUN with step 0 from T+1. leds shows pattern[0] from T+1.
- An ungated step k lasts dwell[k]+1 cycles. dwell = 0 gives a 1-cycle step.
- A gated step with advance already high at cnt = 0 adds no cycles.
- A gated step with advance low at cnt = 0 enters WAIT. Advance high at edge A moves to the next step from A+1.
- FINISH lasts exactly FINISH_CYCLES cycles, then one or more IDLE cycles.
- One-shot total run time = Σ(dwell[k]+1) + wait cycles + FINISH_CYCLES.
- An asynchronous reset mid-run takes effect immediately. The step table is cleared.

## Test plan
- Reset check: assert reset_n = 0 mid-run at a random point. leds must go to 8'hAA, idle = 1 and busy = 0 without waiting for a clock edge. The table must read back as cleared: a following start runs pattern 0 with 1-cycle steps.
- One-shot run: program steps 0..2 = (8'h01, dwell 0), (8'h02, dwell 2), (8'h04, dwell 1), last_step = 2, loop = 0, start pulsed at T. Required leds sequence:
  - 01 at T+1.
  - 02 at T+2..T+4.
  - 04 at T+5..T+6.
  - 8'h18 with finish = 1 at T+7..T+22.
  - idle = 1 at T+23.
- Gate: step 1 has gate = 1 and dwell 0. Hold advance = 0 for 5 cycles after step 1 reaches cnt = 0. waiting = 1 and leds = pattern[1] throughout; a 1-cycle advance pulse moves to step 2 on the next cycle. Rerun with advance held high: no WAIT cycle.
- Loop and abort: loop = 1, last_step = 1. The step index must cycle 0,1,0,1,… with no FINISH. abort = 1 during step 1 gives idle = 1 and leds = 8'hAA on the next cycle.
- Ignored inputs: cfg_we to step 0 while busy, and start pulses during RUN and FINISH. The table must be unchanged and the run timing identical to the undisturbed run. A cfg_we in the same cycle as start in IDLE is dropped.
- Back-to-back: start held high continuously with last_step = 0 and dwell 0. The required period is RUN 1 cycle, FINISH 16 cycles, IDLE 1 cycle, repeating.

Source files
------------

// File: rtl/led_seq_engine.sv
// rtl/led_seq_engine.sv - programmable LED step sequencer with gated steps, loop mode and timed finish hold
module led_seq_engine #(
    parameter int                LED_W          = 8,
    parameter int                STEPS          = 8,
    parameter int                DWELL_W        = 8,
    parameter int                FINISH_CYCLES  = 16,
    parameter logic [LED_W-1:0]  IDLE_PATTERN   = 8'hAA,
    parameter logic [LED_W-1:0]  FINISH_PATTERN = 8'h18
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       advance,
    input  logic                       abort,
    input  logic                       loop,
    input  logic [$clog2(STEPS)-1:0]   last_step,
    input  logic                       cfg_we,
    input  logic [$clog2(STEPS)-1:0]   cfg_addr,
    input  logic [LED_W-1:0]           cfg_pattern,
    input  logic [DWELL_W-1:0]         cfg_dwell,
    input  logic                       cfg_gate,
    output logic [LED_W-1:0]           leds,
    output logic                       idle,
    output logic                       busy,
    output logic                       waiting,
    output logic                       finish,
    output logic [$clog2(STEPS)-1:0]   step_idx
);
    localparam int AW = $clog2(STEPS);
    localparam int FW = $clog2(FINISH_CYCLES + 1);
    localparam logic [FW-1:0] FIN_LAST = FW'(FINISH_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_RUN  = 4'b0010,
        S_WAIT = 4'b0100,
        S_FIN  = 4'b1000
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      k_q, k_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [FW-1:0]      fcnt_q, fcnt_d;
    logic               loop_q, loop_d;
    logic [AW-1:0]      last_q, last_d;
    logic               step_next;
    logic               wr_en;

    logic [LED_W-1:0]   pat_mem   [STEPS];
    logic [DWELL_W-1:0] dwell_mem [STEPS];
    logic               gate_mem  [STEPS];

    // Table is only writable while parked in IDLE and not about to launch a run.
    assign wr_en = cfg_we && (state_q == S_IDLE) && !start;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        fcnt_d    = fcnt_q;
        loop_d    = loop_q;
        last_d    = last_q;
        step_next = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    k_d     = '0;
                    cnt_d   = dwell_mem[0];
                    loop_d  = loop;
                    last_d  = last_step;
                end
            end
            S_RUN: begin
                if (cnt_q != '0)
                    cnt_d = cnt_q - 1'b1;
                else if (gate_mem[k_q] && !advance)
                    state_d = S_WAIT;
                else
                    step_next = 1'b1;
            end
            S_WAIT: begin
                if (advance)
                    step_next = 1'b1;
            end
            S_FIN: begin
                if (fcnt_q == FIN_LAST)
                    state_d = S_IDLE;
                else
                    fcnt_d = fcnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Shared end-of-step action for RUN at cnt 0 and for a released WAIT.
        if (step_next) begin
            if (k_q != last_q) begin
                state_d = S_RUN;
                k_d     = k_q + 1'b1;
                cnt_d   = dwell_mem[k_q + 1'b1];
            end else if (loop_q) begin
                state_d = S_RUN;
                k_d     = '0;
                cnt_d   = dwell_mem[0];
            end else begin
                state_d = S_FIN;
                k_d     = '0;
                fcnt_d  = '0;
            end
        end

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            k_d     = '0;
            cnt_d   = '0;
            fcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            loop_q  <= 1'b0;
            last_q  <= '0;
            for (int i = 0; i < STEPS; i++) begin
                pat_mem[i]   <= '0;
                dwell_mem[i] <= '0;
                gate_mem[i]  <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            loop_q  <= loop_d;
            last_q  <= last_d;
            if (wr_en) begin
                pat_mem[cfg_addr]   <= cfg_pattern;
                dwell_mem[cfg_addr] <= cfg_dwell;
                gate_mem[cfg_addr]  <= cfg_gate;
            end
        end
    end

    assign idle     = (state_q == S_IDLE);
    assign busy     = (state_q == S_RUN) || (state_q == S_WAIT);
    assign waiting  = (state_q == S_WAIT);
    assign finish   = (state_q == S_FIN);
    assign step_idx = busy ? k_q : '0;

    always_comb begin
        leds = IDLE_PATTERN;
        if (busy)
            leds = pat_mem[k_q];
        else if (finish)
            leds = FINISH_PATTERN;
    end
endmodule

// File: tb/tb_led_seq_engine.sv
// tb/tb_led_seq_engine.sv - directed self-checking bench for led_seq_engine
module tb_led_seq_engine;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, advance = 1'b0, abort = 1'b0, loop = 1'b0;
    logic [2:0] last_step = 3'd0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = 3'd0;
    logic [7:0] cfg_pattern = 8'h00, cfg_dwell = 8'h00;
    logic       cfg_gate = 1'b0;
    logic [7:0] leds;
    logic       idle, busy, waiting, finish;
    logic [2:0] step_idx;

    int errors = 0;
    int checks = 0;

    led_seq_engine dut (
        .clk(clk), .reset_n(reset_n), .start(start), .advance(advance), .abort(abort),
        .loop(loop), .last_step(last_step), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_pattern(cfg_pattern), .cfg_dwell(cfg_dwell), .cfg_gate(cfg_gate),
        .leds(leds), .idle(idle), .busy(busy), .waiting(waiting), .finish(finish),
        .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    task automatic write_step(input logic [2:0] a, input logic [7:0] p, input logic [7:0] d, input logic g);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_pattern = p; cfg_dwell = d; cfg_gate = g;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    function automatic logic [7:0] os_leds(input int i);
        if (i == 1)       return 8'h01;
        else if (i <= 4)  return 8'h02;
        else if (i <= 6)  return 8'h04;
        else if (i <= 22) return 8'h18;
        else              return 8'hAA;
    endfunction

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (leds !== 8'hAA) begin errors++; $display("FAIL reset_leds: got %h want aa", leds); end
        checks++; if ({idle, busy, waiting, finish} !== 4'b1000) begin errors++; $display("FAIL reset_status: got %b want 1000", {idle, busy, waiting, finish}); end
        checks++; if (step_idx !== 3'd0) begin errors++; $display("FAIL reset_step_idx: got %0d want 0", step_idx); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_one_shot;
        write_step(3'd0, 8'h01, 8'd0, 1'b0);
        write_step(3'd1, 8'h02, 8'd2, 1'b0);
        write_step(3'd2, 8'h04, 8'd1, 1'b0);
        last_step = 3'd2; loop = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 23; i++) begin
            @(negedge clk);
            start = 1'b0;
            checks++; if (leds !== os_leds(i)) begin errors++; $display("FAIL one_shot_leds cyc%0d: got %h want %h", i, leds, os_leds(i)); end
            checks++; if (finish !== (i >= 7 && i <= 22)) begin errors++; $display("FAIL one_shot_finish cyc%0d: got %b", i, finish); end
            checks++; if (idle !== (i == 23)) begin errors++; $display("FAIL one_shot_idle cyc%0d: got %b", i, idle); end
        end
    endtask

    task automatic test_gate;
        logic [7:0] exp;
        write_step(3'd0, 8'h01, 8'd0, 1'b0);
        write_step(3'd1, 8'h02, 8'd0, 1'b1);
        write_step(3'd2, 8'h04, 8'd0, 1'b0);
        last_step = 3'd2; loop = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            start = 1'b0;
            advance = 1'b0;
            exp = (i == 1) ? 8'h01 : (i <= 7) ? 8'h02 : (i == 8) ? 8'h04 : 8'h18;
            checks++; if (leds !== exp) begin errors++; $display("FAIL gate_leds cyc%0d: got %h want %h", i, leds, exp); end
            checks++; if (waiting !== (i >= 3 && i <= 7)) begin errors++; $display("FAIL gate_waiting cyc%0d: got %b", i, waiting); end
            if (i == 7) advance = 1'b1;
        end
        checks++; if (finish !== 1'b1) begin errors++; $display("FAIL gate_finish: got %b want 1", finish); end
        for (int n = 0; n < 40 && !idle; n++) @(negedge clk);
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL gate_idle_timeout: got %b want 1", idle); end

        advance = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            exp = (i == 1) ? 8'h01 : (i == 2) ? 8'h02 : (i == 3) ? 8'h04 : 8'h18;
            checks++; if (leds !== exp) begin errors++; $display("FAIL gate_adv_leds cyc%0d: got %h want %h", i, leds, exp); end
            checks++; if (waiting !== 1'b0) begin errors++; $display("FAIL gate_adv_waiting cyc%0d: got %b want 0", i, waiting); end
        end
        advance = 1'b0;
        for (int n = 0; n < 40 && !idle; n++) @(negedge clk);
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL gate_adv_idle_timeout: got %b want 1", idle); end
    endtask

    task automatic test_loop_abort;
        logic [2:0] exp_k;
        write_step(3'd0, 8'h11, 8'd0, 1'b0);
        write_step(3'd1, 8'h22, 8'd1, 1'b0);
        last_step = 3'd1; loop = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            start = 1'b0;
            exp_k = (i % 3 == 1) ? 3'd0 : 3'd1;
            checks++; if (step_idx !== exp_k) begin errors++; $display("FAIL loop_step_idx cyc%0d: got %0d want %0d", i, step_idx, exp_k); end
            checks++; if (finish !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL loop_status cyc%0d: got busy=%b finish=%b want 1/0", i, busy, finish); end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; loop = 1'b0;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL abort_idle: got %b want 1", idle); end
        checks++; if (leds !== 8'hAA) begin errors++; $display("FAIL abort_leds: got %h want aa", leds); end
    endtask

    task automatic test_ignored;
        write_step(3'd0, 8'h01, 8'd0, 1'b0);
        write_step(3'd1, 8'h02, 8'd2, 1'b0);
        write_step(3'd2, 8'h04, 8'd1, 1'b0);
        last_step = 3'd2; loop = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 23; i++) begin
            @(negedge clk);
            start = 1'b0;
            cfg_we = 1'b0;
            checks++; if (leds !== os_leds(i)) begin errors++; $display("FAIL ignored_leds cyc%0d: got %h want %h", i, leds, os_leds(i)); end
            checks++; if (idle !== (i == 23)) begin errors++; $display("FAIL ignored_idle cyc%0d: got %b", i, idle); end
            if (i == 2) begin
                cfg_we = 1'b1; cfg_addr = 3'd0; cfg_pattern = 8'hFF; cfg_dwell = 8'd5; cfg_gate = 1'b1;
            end
            if (i == 3 || i == 10) start = 1'b1;
        end
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_pattern = 8'h77; cfg_dwell = 8'd4; cfg_gate = 1'b0;
        start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        checks++; if (leds !== 8'h01) begin errors++; $display("FAIL start_write_leds0: got %h want 01", leds); end
        @(negedge clk);
        checks++; if (leds !== 8'h02) begin errors++; $display("FAIL start_write_leds1: got %h want 02", leds); end
        for (int n = 0; n < 40 && !idle; n++) @(negedge clk);
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL ignored_idle_timeout: got %b want 1", idle); end
    endtask

    task automatic test_back_to_back;
        int pos;
        logic [7:0] exp;
        write_step(3'd0, 8'h3C, 8'd0, 1'b0);
        last_step = 3'd0; loop = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            pos = (i - 1) % 18;
            exp = (pos == 0) ? 8'h3C : (pos <= 16) ? 8'h18 : 8'hAA;
            checks++; if (leds !== exp) begin errors++; $display("FAIL b2b_leds cyc%0d: got %h want %h", i, leds, exp); end
            checks++; if ({busy, finish, idle} !== {pos == 0, pos >= 1 && pos <= 16, pos == 17}) begin
                errors++; $display("FAIL b2b_status cyc%0d: got %b pos %0d", i, {busy, finish, idle}, pos);
            end
        end
        start = 1'b0;
        @(negedge clk);
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL b2b_stop_idle: got %b want 1", idle); end
    endtask

    task automatic test_async_reset;
        write_step(3'd0, 8'h55, 8'd3, 1'b0);
        write_step(3'd1, 8'h66, 8'd3, 1'b1);
        write_step(3'd2, 8'h77, 8'd3, 1'b0);
        last_step = 3'd2; loop = 1'b0; advance = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (leds !== 8'hAA) begin errors++; $display("FAIL async_reset_leds: got %h want aa", leds); end
        checks++; if (idle !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL async_reset_status: got idle=%b busy=%b want 1/0", idle, busy); end
        @(negedge clk);
        reset_n = 1'b1; advance = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i <= 3) begin
                checks++; if (leds !== 8'h00 || step_idx !== 3'(i - 1)) begin
                    errors++; $display("FAIL cleared_step cyc%0d: got leds %h idx %0d want 00 idx %0d", i, leds, step_idx, i - 1);
                end
            end else begin
                checks++; if (finish !== 1'b1) begin errors++; $display("FAIL cleared_finish: got %b want 1", finish); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_gate();
        test_loop_abort();
        test_ignored();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
